// File: rtl/add_sub.sv
// Accumulating add/subtract calculator: signed-magnitude operand entry, two's
// complement accumulator, sticky overflow, one operation per button press.
module add_sub #(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Equals,
  input  logic         Add,
  input  logic         Subtract,
  input  logic [W-1:0] Number,
  output logic [W-1:0] Result,
  output logic         Overflow,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    X_INIT   = 3'd0,
    X_LOAD_A = 3'd1,
    X_ADD    = 3'd2,
    X_SUB    = 3'd3,
    X_WAIT   = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] result_q, result_d;
  logic         overflow_q, overflow_d;

  logic [W-1:0] number_tc;
  logic [W-1:0] b_op;
  logic [W-1:0] low_sum;
  logic [1:0]   msb_sum;
  logic [W-1:0] r;
  logic         c0;
  logic         ovf;

  // Negating a zero magnitude yields zero, so negative zero needs no special case.
  always_comb begin
    number_tc = {1'b0, Number[W-2:0]};
    if (Number[W-1]) begin
      number_tc = -{1'b0, Number[W-2:0]};
    end
  end

  // Split the add at the MSB so the carry into and out of it are both visible.
  always_comb begin
    c0      = (state_q == X_SUB);
    b_op    = c0 ? ~number_tc : number_tc;
    low_sum = {1'b0, a_q[W-2:0]} + {1'b0, b_op[W-2:0]} + {{(W-1){1'b0}}, c0};
    msb_sum = {1'b0, a_q[W-1]} + {1'b0, b_op[W-1]} + {1'b0, low_sum[W-1]};
    r       = {msb_sum[0], low_sum[W-2:0]};
    ovf     = low_sum[W-1] ^ msb_sum[1];
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      X_INIT: begin
        if (!overflow_q) begin
          if (Equals)        state_d = X_LOAD_A;
          else if (Add)      state_d = X_ADD;
          else if (Subtract) state_d = X_SUB;
        end
      end
      X_LOAD_A: begin
        a_d      = number_tc;
        result_d = number_tc;
        state_d  = X_WAIT;
      end
      X_ADD, X_SUB: begin
        if (ovf) begin
          overflow_d = 1'b1;
        end else begin
          a_d      = r;
          result_d = r;
        end
        state_d = X_WAIT;
      end
      X_WAIT: begin
        if (!Equals && !Add && !Subtract) state_d = X_INIT;
      end
      default: state_d = X_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q    <= X_INIT;
      a_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result    = result_q;
  assign Overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add_sub.sv
// Bench for add_sub: directed calculator scenarios plus random presses,
// scored against an integer model of the calculator.
module tb_add_sub;
  localparam int W = 11;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));
  localparam logic [2:0] ST_INIT = 3'd0;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         equals = 1'b0, add = 1'b0, subtract = 1'b0;
  logic [W-1:0] number = '0;
  logic [W-1:0] result;
  logic         overflow;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];   // {overflow, result} expected per executed operation
  int acc = 0;
  bit movf = 1'b0;

  add_sub #(.W(W)) dut (
    .Clock(clk), .Clear(clear), .Equals(equals), .Add(add), .Subtract(subtract),
    .Number(number), .Result(result), .Overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Calculator model: ints with explicit range test, priority Equals > Add > Subtract.
  task automatic model_apply(input logic [2:0] mask, input logic [W-1:0] num);
    int mag, tc, rr;
    mag = int'(num[W-2:0]);
    tc  = num[W-1] ? -mag : mag;
    if (movf) return;
    if (mask[0]) acc = tc;
    else begin
      rr = mask[1] ? acc + tc : acc - tc;
      if (rr > MAXV || rr < MINV) movf = 1'b1;
      else acc = rr;
    end
    exp_q.push_back({movf, acc[W-1:0]});
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    acc = 0;
    movf = 1'b0;
    exp_q.delete();
  endtask

  task automatic press(input logic [2:0] mask, input logic [W-1:0] num, input int hold);
    bit done;
    @(negedge clk);
    number = num;
    {subtract, add, equals} = mask;
    model_apply(mask, num);
    repeat (hold) @(negedge clk);
    {subtract, add, equals} = 3'b000;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (dbg_state == ST_INIT) done = 1'b1;
    end
    if (!done) chk("return_to_init_timeout", 32'(dbg_state), 32'(ST_INIT));
    @(negedge clk);
  endtask

  // Monitor: an operation cycle not cancelled by Clear yields one output next cycle.
  bit pending = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_op: got res=0x%0h ovf=%0b with nothing expected", result, overflow);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("op_result", 32'({overflow, result}), 32'(e));
      end
    end
    pending = (dbg_state inside {3'd1, 3'd2, 3'd3}) && !clear;
  end

  initial begin
    logic [2:0]   m;
    logic [W-1:0] n;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    #1;
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_INIT));

    do_clear();
    press(3'b001, 11'h005, 1);
    chk("load_5", 32'(result), 32'h005);
    press(3'b010, 11'h403, 1);
    chk("add_neg3", 32'(result), 32'h002);
    chk("add_neg3_ovf", 32'(overflow), 32'd0);
    press(3'b100, 11'h007, 1);
    chk("sub_7", 32'(result), 32'h7FB);
    chk("sub_7_ovf", 32'(overflow), 32'd0);

    do_clear();
    press(3'b001, 11'h3E8, 1);
    press(3'b010, 11'h064, 1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_keep_result", 32'(result), 32'd1000);
    press(3'b010, 11'h064, 2);
    chk("ovf_ignored_result", 32'(result), 32'd1000);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_clear();
    #1;
    chk("clear_result", 32'(result), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);

    press(3'b010, 11'h001, 6);
    chk("hold_one_op", 32'(result), 32'd1);
    press(3'b010, 11'h001, 1);
    chk("second_press", 32'(result), 32'd2);

    press(3'b001, 11'h400, 1);
    chk("neg_zero", 32'(result), 32'd0);
    press(3'b001, 11'h7FF, 1);
    chk("neg_1023", 32'(result), 32'h401);

    // Clear and Add on the same edge: no addition.
    @(negedge clk);
    clear = 1'b1;
    add = 1'b1;
    number = 11'h005;
    @(negedge clk);
    #1;
    chk("clear_add_result", 32'(result), 32'd0);
    chk("clear_add_state", 32'(dbg_state), 32'(ST_INIT));
    clear = 1'b0;
    add = 1'b0;
    acc = 0;
    movf = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Clear landing in the XAdd cycle aborts the update.
    press(3'b001, 11'h005, 1);
    @(negedge clk);
    add = 1'b1;
    number = 11'h003;
    @(negedge clk);
    clear = 1'b1;
    add = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    acc = 0;
    movf = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_INIT));
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      m = 3'($urandom_range(1, 7));
      n = W'($urandom);
      press(m, n, $urandom_range(1, 3));
      chk("rand_result", 32'(result), 32'(acc[W-1:0]));
      chk("rand_ovf", 32'(overflow), 32'(movf));
      if (movf && $urandom_range(0, 2) == 0) do_clear();
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
